param_bus_datapath: RTL and testbench

//  Parametrised single-bus multi-cycle datapath: register file, Y, Z(hi/lo), HI, LO, MAR, MDR on one shared bus.
//  An internal control FSM replaces externally driven in/out strobes.

---
 rtl/dp_pkg.sv | 22 ++
 rtl/dp_regfile.sv | 32 +++
 rtl/param_bus_datapath.sv | 167 ++++++++++++++++
 tb/tb_param_bus_datapath.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_pkg.sv
// Shared encodings for the single-bus datapath: opcodes, control states and
// bus-source selects.
package dp_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam logic [2:0] OP_LOAD = 3'b101;
  localparam logic [2:0] OP_MFHI = 3'b110;
  localparam logic [2:0] OP_MFLO = 3'b111;

  typedef enum logic [3:0] {
    S_IDLE, S_Y, S_Z, S_WB, S_WBL, S_WBH, S_MAR, S_MEM, S_WBM
  } state_t;

  typedef enum logic [2:0] {
    SRC_NONE, SRC_REG, SRC_ZLO, SRC_ZHI, SRC_HI, SRC_LO, SRC_MDR
  } bus_src_t;

endpackage

// File: rtl/dp_regfile.sv
// General register file: one synchronous write port, two combinational read
// ports (one feeds the bus, one serves debug reads).
module dp_regfile #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr_a,
  output logic [DATA_W-1:0] o_rdata_a,
  input  logic [AW-1:0]     i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_b
);

  logic [DATA_W-1:0] r_mem [NUM_REGS];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/param_bus_datapath.sv
// Single-bus multi-cycle datapath: an internal FSM sequences each op over one
// shared bus (register file, Y, Z, HI, LO, MAR, MDR) and writes the result back.
module param_bus_datapath
  import dp_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int NUM_REGS    = 16,
  parameter int MEM_TIMEOUT = 15,
  localparam int AW         = $clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [AW-1:0]     ra,
  input  logic [AW-1:0]     rb,
  input  logic [AW-1:0]     rc,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              mem_req,
  output logic [DATA_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [AW-1:0]     dbg_sel,
  output logic [DATA_W-1:0] dbg_data,
  output logic [DATA_W-1:0] bus_mon,
  output logic [3:0]        dbg_state
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  state_t              r_state;
  logic [2:0]          r_op;
  logic [AW-1:0]       r_ra, r_rb, r_rc;
  logic [DATA_W-1:0]   r_y, r_hi, r_lo, r_mar, r_mdr;
  logic [2*DATA_W-1:0] r_z;
  logic [CW-1:0]       r_cnt;

  state_t              w_next;
  bus_src_t            w_src;
  logic [AW-1:0]       w_rd_sel;
  logic [DATA_W-1:0]   w_rd_data, w_bus;
  logic [2*DATA_W-1:0] w_alu;
  logic                w_we, w_cnt_last;

  dp_regfile #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .AW(AW)) u_regfile (
    .i_clk(clock), .i_rst(clear), .i_we(w_we), .i_waddr(r_rc), .i_wdata(w_bus),
    .i_raddr_a(w_rd_sel), .o_rdata_a(w_rd_data),
    .i_raddr_b(dbg_sel), .o_rdata_b(dbg_data)
  );

  // The 15th waiting cycle is the last; an ack in that same cycle still wins.
  assign w_cnt_last = (r_cnt == CW'(MEM_TIMEOUT - 1));

  always_comb begin
    w_next   = r_state;
    w_src    = SRC_NONE;
    w_rd_sel = r_ra;
    w_we     = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    mem_req  = 1'b0;
    case (r_state)
      S_IDLE: if (start) begin
        case (op)
          OP_LOAD:          w_next = S_MAR;
          OP_MFHI, OP_MFLO: w_next = S_WB;
          default:          w_next = S_Y;
        endcase
      end
      S_Y: begin w_src = SRC_REG; w_next = S_Z; end
      S_Z: begin
        w_src    = SRC_REG;
        w_rd_sel = r_rb;
        w_next   = (r_op == OP_MUL) ? S_WBL : S_WB;
      end
      S_WB: begin
        w_src  = (r_op == OP_MFHI) ? SRC_HI : (r_op == OP_MFLO) ? SRC_LO : SRC_ZLO;
        w_we   = 1'b1;
        done   = 1'b1;
        w_next = S_IDLE;
      end
      S_WBL: begin w_src = SRC_ZLO; w_next = S_WBH; end
      S_WBH: begin w_src = SRC_ZHI; done = 1'b1; w_next = S_IDLE; end
      S_MAR: begin w_src = SRC_REG; w_next = S_MEM; end
      S_MEM: begin
        mem_req = 1'b1;
        if (mem_ack) w_next = S_WBM;
        else if (w_cnt_last) begin
          error  = 1'b1;
          w_next = S_IDLE;
        end
      end
      S_WBM: begin w_src = SRC_MDR; w_we = 1'b1; done = 1'b1; w_next = S_IDLE; end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_bus = '0;
    case (w_src)
      SRC_REG: w_bus = w_rd_data;
      SRC_ZLO: w_bus = r_z[DATA_W-1:0];
      SRC_ZHI: w_bus = r_z[2*DATA_W-1:DATA_W];
      SRC_HI:  w_bus = r_hi;
      SRC_LO:  w_bus = r_lo;
      SRC_MDR: w_bus = r_mdr;
      default: w_bus = '0;
    endcase
  end

  always_comb begin
    w_alu = '0;
    case (r_op)
      OP_ADD: w_alu = {{DATA_W{1'b0}}, r_y + w_bus};
      OP_SUB: w_alu = {{DATA_W{1'b0}}, r_y - w_bus};
      OP_AND: w_alu = {{DATA_W{1'b0}}, r_y & w_bus};
      OP_OR:  w_alu = {{DATA_W{1'b0}}, r_y | w_bus};
      OP_MUL: w_alu = {{DATA_W{1'b0}}, r_y} * {{DATA_W{1'b0}}, w_bus};
      default: w_alu = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_ra    <= '0;
      r_rb    <= '0;
      r_rc    <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_mar   <= '0;
      r_mdr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && start) begin
        r_op <= op;
        r_ra <= ra;
        r_rb <= rb;
        r_rc <= rc;
      end
      case (r_state)
        S_Y:   r_y <= w_bus;
        S_Z:   r_z <= w_alu;
        S_WBL: r_lo <= w_bus;
        S_WBH: r_hi <= w_bus;
        S_MAR: begin r_mar <= w_bus; r_cnt <= '0; end
        S_MEM: begin
          r_cnt <= r_cnt + 1'b1;
          if (mem_ack) r_mdr <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign mem_addr  = r_mar;
  assign bus_mon   = w_bus;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_param_bus_datapath.sv
// Directed bench for param_bus_datapath: a 32-bit/16-reg instance for the main
// scenarios and a 16-bit/8-reg instance for the narrow SUB wrap.
module tb_param_bus_datapath;
  import dp_pkg::*;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [3:0]  ra = '0, rb = '0, rc = '0, dbg_sel = '0;
  logic        busy, done, error, mem_req;
  logic [31:0] mem_addr, dbg_data, bus_mon;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [3:0]  dbg_state;

  logic        start16 = 1'b0;
  logic [2:0]  op16 = '0;
  logic [2:0]  ra16 = '0, rb16 = '0, rc16 = '0, dbg_sel16 = '0;
  logic        busy16, done16, error16, mem_req16;
  logic [15:0] mem_addr16, dbg_data16, bus_mon16;
  logic        mem_ack16 = 1'b0;
  logic [15:0] mem_rdata16 = '0;
  logic [3:0]  dbg_state16;

  int checks = 0;
  int failures = 0;
  int res_busy, res_done, res_err, res_req;
  logic [31:0] res_addr;

  always #5 clock = ~clock;

  param_bus_datapath #(.DATA_W(32), .NUM_REGS(16), .MEM_TIMEOUT(15)) dut (
    .clock(clock), .clear(clear), .start(start), .op(op), .ra(ra), .rb(rb), .rc(rc),
    .busy(busy), .done(done), .error(error), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .dbg_sel(dbg_sel), .dbg_data(dbg_data),
    .bus_mon(bus_mon), .dbg_state(dbg_state)
  );

  param_bus_datapath #(.DATA_W(16), .NUM_REGS(8), .MEM_TIMEOUT(15)) dut16 (
    .clock(clock), .clear(clear), .start(start16), .op(op16), .ra(ra16), .rb(rb16), .rc(rc16),
    .busy(busy16), .done(done16), .error(error16), .mem_req(mem_req16), .mem_addr(mem_addr16),
    .mem_ack(mem_ack16), .mem_rdata(mem_rdata16), .dbg_sel(dbg_sel16), .dbg_data(dbg_data16),
    .bus_mon(bus_mon16), .dbg_state(dbg_state16)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic read_reg(input logic [3:0] idx, output logic [31:0] val);
    dbg_sel = idx;
    #1;
    val = dbg_data;
  endtask

  // Issues one op and services mem_req; ack_wait<0 means never acknowledge.
  task automatic run_op(input logic [2:0] o, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input int ack_wait, input logic [31:0] rdata);
    int w;
    @(negedge clock);
    start = 1'b1; op = o; ra = a; rb = b; rc = c;
    @(negedge clock);
    start = 1'b0;
    res_busy = 0; res_done = 0; res_err = 0; res_req = 0; res_addr = 'x; w = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (!busy) break;
      res_busy++;
      res_done += int'(done);
      res_err  += int'(error);
      mem_ack = 1'b0;
      if (mem_req) begin
        res_req++;
        res_addr = mem_addr;
        if (ack_wait >= 0 && w == ack_wait) begin
          mem_ack = 1'b1;
          mem_rdata = rdata;
        end
        w++;
      end
      @(negedge clock);
    end
    mem_ack = 1'b0;
    if (busy) check("op_cycle_budget", 32'(busy), 32'd0);
  endtask

  task automatic load(input logic [3:0] c, input logic [31:0] v);
    run_op(OP_LOAD, 4'd0, 4'd0, c, 0, v);
  endtask

  task automatic run16(input logic [2:0] o, input logic [2:0] a, input logic [2:0] b,
                       input logic [2:0] c, input logic [15:0] v);
    @(negedge clock);
    start16 = 1'b1; op16 = o; ra16 = a; rb16 = b; rc16 = c;
    @(negedge clock);
    start16 = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (!busy16) break;
      mem_ack16 = mem_req16;
      mem_rdata16 = v;
      @(negedge clock);
    end
    mem_ack16 = 1'b0;
    if (busy16) check("op16_cycle_budget", 32'(busy16), 32'd0);
  endtask

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [3:0]  ra, rb, rc;
    logic [31:0] v1, v2, exp;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [31:0] rv, acc;
    int done_c;

    vecs[0] = '{"add",       OP_ADD, 4'd1, 4'd2, 4'd3, 32'd5,    32'd7,    32'd12};
    vecs[1] = '{"sub",       OP_SUB, 4'd1, 4'd2, 4'd4, 32'd5,    32'd7,    32'hFFFF_FFFE};
    vecs[2] = '{"and",       OP_AND, 4'd1, 4'd2, 4'd3, 32'hF0,   32'h3C,   32'h30};
    vecs[3] = '{"or",        OP_OR,  4'd1, 4'd2, 4'd4, 32'hF0,   32'h3C,   32'hFC};
    vecs[4] = '{"add_alias", OP_ADD, 4'd1, 4'd1, 4'd1, 32'd3,    32'd0,    32'd6};

    repeat (2) @(negedge clock);
    clear = 1'b0;

    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(error), 0);
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_bus_mon", bus_mon, 0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    read_reg(4'd15, rv);
    check("rst_r15", rv, 0);

    // LOAD with two wait cycles before the ack.
    run_op(OP_LOAD, 4'd0, 4'd0, 4'd1, 2, 32'd5);
    check("load_addr", res_addr, 0);
    check("load_busy_cycles", 32'(res_busy), 5);
    check("load_done_count", 32'(res_done), 1);
    check("load_req_cycles", 32'(res_req), 3);
    check("load_error_count", 32'(res_err), 0);
    read_reg(4'd1, rv);
    check("load_r1", rv, 32'd5);

    foreach (vecs[i]) begin
      load(4'd1, vecs[i].v1);
      if (vecs[i].rb != vecs[i].ra) load(vecs[i].rb, vecs[i].v2);
      run_op(vecs[i].op, vecs[i].ra, vecs[i].rb, vecs[i].rc, -1, 0);
      check({vecs[i].name, "_busy_cycles"}, 32'(res_busy), 3);
      check({vecs[i].name, "_done_count"}, 32'(res_done), 1);
      read_reg(vecs[i].rc, rv);
      check({vecs[i].name, "_result"}, rv, vecs[i].exp);
    end

    // MUL into HI/LO, then move both out.
    load(4'd1, 32'hFFFF_FFFF);
    load(4'd2, 32'd2);
    load(4'd3, 32'hAA);
    run_op(OP_MUL, 4'd1, 4'd2, 4'd3, -1, 0);
    check("mul_busy_cycles", 32'(res_busy), 4);
    check("mul_done_count", 32'(res_done), 1);
    read_reg(4'd3, rv);
    check("mul_rc_untouched", rv, 32'hAA);
    run_op(OP_MFHI, 4'd0, 4'd0, 4'd5, -1, 0);
    check("mfhi_busy_cycles", 32'(res_busy), 1);
    check("mfhi_done_count", 32'(res_done), 1);
    read_reg(4'd5, rv);
    check("mfhi_r5", rv, 32'd1);
    run_op(OP_MFLO, 4'd0, 4'd0, 4'd6, -1, 0);
    read_reg(4'd6, rv);
    check("mflo_r6", rv, 32'hFFFF_FFFE);

    // LOAD that never gets an ack.
    load(4'd9, 32'h1234);
    run_op(OP_LOAD, 4'd0, 4'd0, 4'd9, -1, 32'hDEAD);
    check("timeout_req_cycles", 32'(res_req), 15);
    check("timeout_busy_cycles", 32'(res_busy), 16);
    check("timeout_error_count", 32'(res_err), 1);
    check("timeout_done_count", 32'(res_done), 0);
    check("timeout_req_dropped", 32'(mem_req), 0);
    read_reg(4'd9, rv);
    check("timeout_r9_kept", rv, 32'h1234);

    // Second start while busy is dropped.
    load(4'd1, 32'd5);
    load(4'd2, 32'd7);
    @(negedge clock);
    start = 1'b1; op = OP_ADD; ra = 4'd1; rb = 4'd2; rc = 4'd3;
    @(negedge clock);
    op = OP_OR; rc = 4'd7;
    @(negedge clock);
    start = 1'b0;
    done_c = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      done_c += int'(done);
      @(negedge clock);
    end
    check("ignore_done_count", 32'(done_c), 1);
    check("ignore_busy_after", 32'(busy), 0);
    read_reg(4'd3, rv);
    check("ignore_r3", rv, 32'd12);
    read_reg(4'd7, rv);
    check("ignore_r7", rv, 32'd0);

    // clear asserted during S_Z aborts the op.
    @(negedge clock);
    start = 1'b1; op = OP_ADD; ra = 4'd1; rb = 4'd2; rc = 4'd8;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    check("pre_clear_state", 32'(dbg_state), 32'(S_Z));
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    check("clr_busy", 32'(busy), 0);
    check("clr_done", 32'(done), 0);
    check("clr_mem_addr", mem_addr, 0);
    check("clr_bus_mon", bus_mon, 0);
    acc = '0;
    for (int i = 0; i < 16; i++) begin
      read_reg(4'(i), rv);
      acc |= rv;
    end
    check("clr_all_regs_zero", acc, 0);
    @(negedge clock);
    check("clr_no_late_done", 32'(done), 0);

    // clear and start together: clear wins.
    clear = 1'b1; start = 1'b1; op = OP_ADD;
    @(negedge clock);
    clear = 1'b0; start = 1'b0;
    check("clr_start_busy", 32'(busy), 0);
    @(negedge clock);
    check("clr_start_busy_later", 32'(busy), 0);

    // Narrow instance.
    run16(OP_LOAD, 3'd0, 3'd0, 3'd1, 16'd5);
    run16(OP_LOAD, 3'd0, 3'd0, 3'd2, 16'd7);
    run16(OP_SUB, 3'd1, 3'd2, 3'd4, 16'd0);
    run16(OP_ADD, 3'd1, 3'd2, 3'd3, 16'd0);
    dbg_sel16 = 3'd4;
    #1;
    check("w16_sub", 32'(dbg_data16), 32'h0000_FFFE);
    dbg_sel16 = 3'd3;
    #1;
    check("w16_add", 32'(dbg_data16), 32'd12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
